// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle runner game sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        WIN  = 2'd3
    } game_state_t;

    // Spawn probability out of 16, indexed by level; later levels get denser.
    localparam logic [4:0] SPAWN_THR [3] = '{5'd4, 5'd6, 5'd8};

    // Galois mask for x^16+x^14+x^13+x^11+1, right-shifting form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [4:0] spawn_thr(input int unsigned lvl);
        case (lvl)
            0:       return SPAWN_THR[0];
            1:       return SPAWN_THR[1];
            default: return SPAWN_THR[2];
        endcase
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used as the obstacle spawn source; advances only when en is high.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= SEED;
        else if (en)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game sequencer: MENU/RUN/DEAD/WIN state, game timer, scrolling obstacle bitmap and level progression.
module obstacle_scheduler
    import game_pkg::*;
#(
    parameter int          NUM_SLOTS      = 20,
    parameter int          SLOT_W         = 32,
    parameter int          OBST_PER_LEVEL = 16,
    parameter int          NUM_LEVELS     = 3,
    parameter int          MIN_GAP        = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          player_hit,
    output logic [NUM_SLOTS-1:0]          slots,
    output logic [$clog2(SLOT_W)-1:0]     scroll_off,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic [15:0]                   game_time,
    output logic                          menu_screen,
    output logic                          death_screen,
    output logic                          victory_screen,
    output logic                          obj_reset
);

    localparam int SCW = $clog2(SLOT_W);
    localparam int LW  = $clog2(NUM_LEVELS);
    localparam int CW  = $clog2(OBST_PER_LEVEL + 1);

    game_state_t   state;
    logic          start_q;
    logic          start_edge;
    logic [CW-1:0] clr_cnt;
    logic [CW-1:0] clr_inc;
    logic [15:0]   lfsr_q;
    logic          lfsr_unused;
    logic [SCW:0]  sum;
    logic          over;
    logic          shift;
    logic          spawn;
    logic          level_done;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (shift),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:4];

    always_comb begin
        start_edge = start & ~start_q;
        sum        = {1'b0, scroll_off} + (SCW+1)'(level) + (SCW+1)'(1);
        over       = sum >= (SCW+1)'(SLOT_W);
        shift      = (state == RUN) && tick && !player_hit && over;
        spawn      = ({1'b0, lfsr_q[3:0]} < spawn_thr(int'(level)))
                     && !(|slots[NUM_SLOTS-1 -: MIN_GAP]);
        clr_inc    = clr_cnt + 1'b1;
        level_done = slots[0] && (clr_inc == CW'(OBST_PER_LEVEL));
    end

    // SLOT_W is a power of two and sum < 2*SLOT_W, so dropping the top bit of sum
    // yields either sum or sum - SLOT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MENU;
            slots      <= '0;
            scroll_off <= '0;
            level      <= '0;
            game_time  <= '0;
            clr_cnt    <= '0;
            obj_reset  <= 1'b0;
            start_q    <= start;
        end else begin
            start_q   <= start;
            obj_reset <= 1'b0;
            case (state)
                MENU: begin
                    if (start_edge) begin
                        state      <= RUN;
                        obj_reset  <= 1'b1;
                        slots      <= '0;
                        scroll_off <= '0;
                        level      <= '0;
                        game_time  <= '0;
                        clr_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (player_hit) begin
                        state <= DEAD;
                    end else if (tick) begin
                        if (game_time != 16'hFFFF)
                            game_time <= game_time + 16'd1;
                        scroll_off <= sum[SCW-1:0];
                        if (over) begin
                            slots <= {spawn, slots[NUM_SLOTS-1:1]};
                            if (slots[0]) begin
                                if (level_done) begin
                                    clr_cnt <= '0;
                                    if (level == LW'(NUM_LEVELS - 1))
                                        state <= WIN;
                                    else
                                        level <= level + 1'b1;
                                end else begin
                                    clr_cnt <= clr_inc;
                                end
                            end
                        end
                    end
                end
                DEAD, WIN: begin
                    if (start_edge)
                        state <= MENU;
                end
                default: state <= MENU;
            endcase
        end
    end

    assign menu_screen    = (state == MENU);
    assign death_screen   = (state == DEAD);
    assign victory_screen = (state == WIN);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench: a behavioural game model feeds a scoreboard queue for two DUT configurations.
module tb_obstacle_scheduler;

    logic clk = 1'b0;
    logic reset, tick, start, player_hit;

    logic [19:0] slots0, slots1;
    logic [4:0]  scroll0, scroll1;
    logic [1:0]  level0;
    logic [0:0]  level1;
    logic [15:0] gt0, gt1;
    logic menu0, dead0, win0, objr0;
    logic menu1, dead1, win1, objr1;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    obstacle_scheduler dut0 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .player_hit(player_hit),
        .slots(slots0), .scroll_off(scroll0), .level(level0), .game_time(gt0),
        .menu_screen(menu0), .death_screen(dead0), .victory_screen(win0), .obj_reset(objr0)
    );

    obstacle_scheduler #(
        .OBST_PER_LEVEL(2), .NUM_LEVELS(2)
    ) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .player_hit(player_hit),
        .slots(slots1), .scroll_off(scroll1), .level(level1), .game_time(gt1),
        .menu_screen(menu1), .death_screen(dead1), .victory_screen(win1), .obj_reset(objr1)
    );

    // Model state: 0=MENU 1=RUN 2=DEAD 3=WIN
    typedef struct {
        int          state;
        logic [19:0] slots;
        logic [4:0]  scroll;
        logic [1:0]  level;
        logic [15:0] gt;
        int          clr;
        logic [15:0] lfsr;
        logic        start_q;
        logic        objr;
    } mdl_t;

    mdl_t m0, m1, e0, e1;
    mdl_t q0[$];
    mdl_t q1[$];

    function automatic mdl_t mstep(input mdl_t m, input logic rst, input logic tk,
                                   input logic st, input logic hit, input int opl, input int nl);
        mdl_t n;
        logic edge_s, spawn, outgoing;
        int   sum, thr;
        n = m;
        n.objr = 1'b0;
        n.start_q = st;
        edge_s = st & ~m.start_q;
        if (rst) begin
            n.state = 0; n.slots = '0; n.scroll = '0; n.level = '0;
            n.gt = '0; n.clr = 0; n.lfsr = 16'hACE1;
            return n;
        end
        case (m.state)
            0: if (edge_s) begin
                n.state = 1; n.objr = 1'b1; n.slots = '0; n.scroll = '0;
                n.level = '0; n.gt = '0; n.clr = 0;
            end
            1: if (hit) begin
                n.state = 2;
            end else if (tk) begin
                if (m.gt != 16'hFFFF) n.gt = m.gt + 16'd1;
                sum = int'(m.scroll) + int'(m.level) + 1;
                if (sum < 32) begin
                    n.scroll = 5'(sum);
                end else begin
                    n.scroll = 5'(sum - 32);
                    thr = (m.level == 2'd0) ? 4 : (m.level == 2'd1) ? 6 : 8;
                    spawn = (int'(m.lfsr[3:0]) < thr) && (m.slots[19:18] == 2'b00);
                    outgoing = m.slots[0];
                    n.slots = {spawn, m.slots[19:1]};
                    n.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 16'hB400) : (m.lfsr >> 1);
                    if (outgoing) begin
                        n.clr = m.clr + 1;
                        if (n.clr == opl) begin
                            n.clr = 0;
                            if (int'(m.level) == nl - 1) n.state = 3;
                            else n.level = m.level + 2'd1;
                        end
                    end
                end
            end
            default: if (edge_s) n.state = 0;
        endcase
        return n;
    endfunction

    task automatic drive(input logic r, input logic tk, input logic st, input logic hit);
        reset = r; tick = tk; start = st; player_hit = hit;
        m0 = mstep(m0, r, tk, st, hit, 16, 3);
        q0.push_back(m0);
        m1 = mstep(m1, r, tk, st, hit, 2, 2);
        q1.push_back(m1);
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
    endtask

    task automatic test_reset();
        logic objr_seen;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (menu0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_menu: got %0b expected 1", menu0); end
        checks++; if ({dead0, win0, objr0} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %03b expected 000", {dead0, win0, objr0}); end
        checks++; if ({scroll0, level0} !== 7'd0) begin errors++; $display("[TB] FAIL reset_scroll_level: got %0h expected 0", {scroll0, level0}); end
        objr_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 1'b0, (i % 3) == 0);
            objr_seen = objr_seen | objr0 | objr1;
        end
        checks++; if (menu0 !== 1'b1) begin errors++; $display("[TB] FAIL menu_idle: got %0b expected 1", menu0); end
        checks++; if (slots0 !== 20'h0) begin errors++; $display("[TB] FAIL menu_slots: got %0h expected 0", slots0); end
        checks++; if (gt0 !== 16'd0) begin errors++; $display("[TB] FAIL menu_time: got %0d expected 0", gt0); end
        checks++; if (objr_seen !== 1'b0) begin errors++; $display("[TB] FAIL menu_objr: got %0b expected 0", objr_seen); end
    endtask

    task automatic test_start();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if ({menu0, objr0} !== 2'b01) begin errors++; $display("[TB] FAIL start_run: got menu,objr=%02b expected 01", {menu0, objr0}); end
        checks++; if ({menu1, objr1} !== 2'b01) begin errors++; $display("[TB] FAIL start_run_small: got menu,objr=%02b expected 01", {menu1, objr1}); end
        for (int i = 1; i <= 32; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 1) begin
                checks++; if (objr0 !== 1'b0) begin errors++; $display("[TB] FAIL objr_width: got %0b expected 0", objr0); end
            end
            if (i == 31) begin
                checks++; if ({slots0, scroll0} !== {20'h0, 5'd31}) begin errors++; $display("[TB] FAIL pre_shift: got slots=%0h scroll=%0d expected 0/31", slots0, scroll0); end
            end
        end
        checks++; if (scroll0 !== 5'd0) begin errors++; $display("[TB] FAIL shift_scroll: got %0d expected 0", scroll0); end
        checks++; if (gt0 !== 16'd32) begin errors++; $display("[TB] FAIL shift_time: got %0d expected 32", gt0); end
        checks++; if (slots0 !== 20'h80000) begin errors++; $display("[TB] FAIL first_spawn: got %0h expected 80000", slots0); end
        checks++; if (slots0 !== e0.slots) begin errors++; $display("[TB] FAIL first_spawn_model: got %0h expected %0h", slots0, e0.slots); end
    endtask

    task automatic test_hit();
        logic [15:0] gt_hold;
        logic [19:0] sl_hold;
        logic [4:0]  sc_hold;
        logic        changed;
        gt_hold = e0.gt; sl_hold = e0.slots; sc_hold = e0.scroll;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (dead0 !== 1'b1) begin errors++; $display("[TB] FAIL hit_dead: got %0b expected 1", dead0); end
        checks++; if ({gt0, slots0, scroll0} !== {gt_hold, sl_hold, sc_hold}) begin errors++; $display("[TB] FAIL hit_frozen: got t=%0d s=%0h expected t=%0d s=%0h", gt0, slots0, gt_hold, sl_hold); end
        changed = 1'b0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            if ({gt0, slots0, scroll0, dead0} !== {gt_hold, sl_hold, sc_hold, 1'b1}) changed = 1'b1;
        end
        checks++; if (changed !== 1'b0) begin errors++; $display("[TB] FAIL dead_hold: got changed=%0b expected 0", changed); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if ({menu0, dead0} !== 2'b10) begin errors++; $display("[TB] FAIL dead_to_menu: got %02b expected 10", {menu0, dead0}); end
        checks++; if (slots0 !== sl_hold) begin errors++; $display("[TB] FAIL menu_data_hold: got %0h expected %0h", slots0, sl_hold); end
    endtask

    task automatic test_long_run();
        logic gap_ok;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if ({slots0, gt0, objr0} !== {20'h0, 16'd0, 1'b1}) begin errors++; $display("[TB] FAIL restart_clear: got s=%0h t=%0d o=%0b expected 0/0/1", slots0, gt0, objr0); end
        for (int i = 0; i < 20000; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            checks++; if (slots0 !== e0.slots) begin errors++; $display("[TB] FAIL long_slots @%0d: got %0h expected %0h", i, slots0, e0.slots); end
            checks++; if ({level0, win0} !== {e0.level, 1'(e0.state == 3)}) begin errors++; $display("[TB] FAIL long_level @%0d: got %0d/%0b expected %0d/%0b", i, level0, win0, e0.level, e0.state == 3); end
            gap_ok = 1'b1;
            for (int b = 0; b < 18; b++)
                if (slots0[b] && (slots0[b+1] || slots0[b+2])) gap_ok = 1'b0;
            checks++; if (gap_ok !== 1'b1) begin errors++; $display("[TB] FAIL min_gap @%0d: slots=%0h", i, slots0); end
        end
    endtask

    task automatic test_levels();
        logic [1:0] prev_lvl;
        logic       pending;
        logic       won;
        logic [4:0] base;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        pending = 1'b0; won = 1'b0; base = '0;
        for (int i = 0; i < 20000 && !won; i++) begin
            prev_lvl = e1.level;
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            checks++; if ({level1, scroll1, win1} !== {e1.level[0], e1.scroll, 1'(e1.state == 3)}) begin errors++; $display("[TB] FAIL small_track @%0d: got %0d/%0d/%0b expected %0d/%0d/%0b", i, level1, scroll1, win1, e1.level, e1.scroll, e1.state == 3); end
            if (pending) begin
                checks++; if (scroll1 !== 5'(base + 5'd2)) begin errors++; $display("[TB] FAIL level1_speed: got %0d expected %0d", scroll1, 5'(base + 5'd2)); end
                pending = 1'b0;
            end
            if (prev_lvl == 2'd0 && e1.level == 2'd1) begin
                checks++; if (level1 !== 1'b1) begin errors++; $display("[TB] FAIL level_up: got %0d expected 1", level1); end
                pending = 1'b1; base = scroll1;
            end
            if (e1.state == 3) won = 1'b1;
        end
        if (!won) begin
            checks++; errors++;
            $display("[TB] FAIL win_timeout: got no win expected win within 20000 ticks");
        end
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if ({win1, level1} !== 2'b11) begin errors++; $display("[TB] FAIL victory: got win,level=%02b expected 11", {win1, level1}); end
    endtask

    task automatic test_reset_mid_run();
        logic started;
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if ({menu0, dead0, win0, objr0} !== 4'b1000) begin errors++; $display("[TB] FAIL midrst_flags: got %04b expected 1000", {menu0, dead0, win0, objr0}); end
        checks++; if ({slots0, scroll0, level0, gt0} !== 43'd0) begin errors++; $display("[TB] FAIL midrst_data: got s=%0h sc=%0d l=%0d t=%0d expected 0", slots0, scroll0, level0, gt0); end
        started = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            if (!menu0 || objr0) started = 1'b1;
        end
        checks++; if (started !== 1'b0) begin errors++; $display("[TB] FAIL held_start: got started=%0b expected 0", started); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if ({menu0, objr0} !== 2'b01) begin errors++; $display("[TB] FAIL repress: got %02b expected 01", {menu0, objr0}); end
        checks++; if ({menu0, objr0} !== {1'(e0.state == 0), e0.objr}) begin errors++; $display("[TB] FAIL repress_model: got %02b expected %0b%0b", {menu0, objr0}, e0.state == 0, e0.objr); end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; player_hit = 1'b0;
        test_reset();
        test_start();
        test_hit();
        test_long_run();
        test_levels();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
